// File: rtl/zeroheti_pkg.sv
// rtl/zeroheti_pkg.sv - shared types and constants for the APB manager arbiter
//
// Purpose : arbiter FSM state encoding and the data word returned on a forced
//           timeout error.
// Ports   : none (package).
package zeroheti_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SETUP,
        ARB_ACCESS
    } apb_arb_state_e;

    localparam logic [31:0] ApbArbErrData = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose : selects the first requester at or after the pointer, wrapping
//           around, and reports it as a one-hot grant.
// Ports   : req   in  NumMgrs  request vector
//           ptr   in  PtrW     index of the highest-priority requester
//           gnt   out NumMgrs  one-hot winner (0 when nobody requests)
//           valid out 1        at least one request present
module rr_pick #(
    parameter int unsigned NumMgrs = 2,
    parameter int unsigned PtrW    = 1
) (
    input  logic [NumMgrs-1:0] req,
    input  logic [PtrW-1:0]    ptr,
    output logic [NumMgrs-1:0] gnt,
    output logic               valid
);

    // One extra bit so ptr+i never overflows before the wrap-around subtract.
    logic [PtrW:0] pos;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int i = 0; i < NumMgrs; i++) begin
            pos = {1'b0, ptr} + (PtrW+1)'(i);
            if (pos >= (PtrW+1)'(NumMgrs)) begin
                pos = pos - (PtrW+1)'(NumMgrs);
            end
            if (!valid && req[pos[PtrW-1:0]]) begin
                gnt[pos[PtrW-1:0]] = 1'b1;
                valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_mgr_arbiter.sv
// rtl/apb_mgr_arbiter.sv - round-robin arbiter sharing one APB port between managers
//
// Purpose : grants one complete APB transfer at a time to one of NumMgrs
//           managers, re-issues SETUP/ACCESS downstream and routes the
//           response back to the granted manager only.
// Config  : APB_ARB_TIMEOUT_EN - when defined, an ACCESS phase that waits
//           TimeoutCycles cycles without pready is ended with pslverr and
//           ApbArbErrData; when undefined ACCESS waits indefinitely.
// Ports   : clk_i, rst_ni                    clock, async active-low reset
//           m_psel_i/m_penable_i/m_pwrite_i  per-manager control
//           m_paddr_i/m_pwdata_i/m_pstrb_i   per-manager address/data/strobes
//           m_prdata_o/m_pready_o/m_pslverr_o per-manager response
//           s_psel_o/s_penable_o/s_pwrite_o  downstream control
//           s_paddr_o/s_pwdata_o/s_pstrb_o   downstream address/data/strobes
//           s_prdata_i/s_pready_i/s_pslverr_i downstream response
//           gnt_o                            one-hot current grant
module apb_mgr_arbiter
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumMgrs       = 2,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumMgrs-1:0]             m_psel_i,
    input  logic [NumMgrs-1:0]             m_penable_i,
    input  logic [NumMgrs-1:0]             m_pwrite_i,
    input  logic [NumMgrs*AddrWidth-1:0]   m_paddr_i,
    input  logic [NumMgrs*DataWidth-1:0]   m_pwdata_i,
    input  logic [NumMgrs*DataWidth/8-1:0] m_pstrb_i,
    output logic [NumMgrs*DataWidth-1:0]   m_prdata_o,
    output logic [NumMgrs-1:0]             m_pready_o,
    output logic [NumMgrs-1:0]             m_pslverr_o,
    output logic                           s_psel_o,
    output logic                           s_penable_o,
    output logic                           s_pwrite_o,
    output logic [AddrWidth-1:0]           s_paddr_o,
    output logic [DataWidth-1:0]           s_pwdata_o,
    output logic [DataWidth/8-1:0]         s_pstrb_o,
    input  logic [DataWidth-1:0]           s_prdata_i,
    input  logic                           s_pready_i,
    input  logic                           s_pslverr_i,
    output logic [NumMgrs-1:0]             gnt_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned PtrW      = (NumMgrs > 1) ? $clog2(NumMgrs) : 1;

    if (NumMgrs < 2 || TimeoutCycles == 0) begin : g_cfg_check
        $error("apb_mgr_arbiter: NumMgrs must be >= 2 and TimeoutCycles >= 1");
    end

    apb_arb_state_e     state_q, state_d;
    logic [NumMgrs-1:0] gnt_q, gnt_d;
    logic [PtrW-1:0]    gidx_q, gidx_d;
    logic [PtrW-1:0]    ptr_q, ptr_d, ptr_next;
    logic [NumMgrs-1:0] pick_gnt;
    logic               pick_valid;
    logic               active, abort, done, tmo_hit, finish, drive;

    // The arbiter only needs psel to track a manager's transfer; its penable
    // is implied by our own SETUP/ACCESS sequencing.
    logic               unused_penable;
    assign unused_penable = ^m_penable_i;

    function automatic logic [PtrW-1:0] oh_idx(input logic [NumMgrs-1:0] oh);
        logic [PtrW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NumMgrs; i++) begin
            if (oh[i]) idx = PtrW'(i);
        end
        return idx;
    endfunction

    rr_pick #(
        .NumMgrs (NumMgrs),
        .PtrW    (PtrW)
    ) u_rr_pick (
        .req   (m_psel_i),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    assign active   = (state_q != ARB_IDLE);
    // The granted manager dropping psel mid-transfer kills the transfer at once.
    assign abort    = active && !m_psel_i[gidx_q];
    assign done     = (state_q == ARB_ACCESS) && !abort && s_pready_i;
    assign finish   = done || tmo_hit;
    assign drive    = active && !abort && !tmo_hit;
    assign ptr_next = (gidx_q == PtrW'(NumMgrs - 1)) ? '0 : gidx_q + PtrW'(1);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] tmo_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ARB_SETUP) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ARB_ACCESS && !s_pready_i && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + CntW'(1);
        end
    end

    assign tmo_hit = (state_q == ARB_ACCESS) && !abort && !s_pready_i &&
                     (tmo_cnt_q == CntW'(TimeoutCycles));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    gidx_d  = oh_idx(pick_gnt);
                    state_d = ARB_SETUP;
                end
            end
            ARB_SETUP: begin
                if (abort) begin
                    state_d = ARB_IDLE;
                    ptr_d   = ptr_next;
                end else begin
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (abort || finish) begin
                    state_d = ARB_IDLE;
                    ptr_d   = ptr_next;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign s_psel_o    = drive;
    assign s_penable_o = drive && (state_q == ARB_ACCESS);
    assign s_pwrite_o  = drive && m_pwrite_i[gidx_q];
    assign s_paddr_o   = drive ? m_paddr_i[gidx_q*AddrWidth +: AddrWidth]  : '0;
    assign s_pwdata_o  = drive ? m_pwdata_i[gidx_q*DataWidth +: DataWidth] : '0;
    assign s_pstrb_o   = drive ? m_pstrb_i[gidx_q*StrbWidth +: StrbWidth]  : '0;
    assign gnt_o       = active ? gnt_q : '0;

    // Only the granted manager ever sees a non-zero response.
    always_comb begin
        m_pready_o  = '0;
        m_pslverr_o = '0;
        m_prdata_o  = '0;
        if (finish) begin
            m_pready_o = gnt_q;
            for (int i = 0; i < NumMgrs; i++) begin
                if (gnt_q[i]) begin
                    m_pslverr_o[i] = tmo_hit || s_pslverr_i;
                    m_prdata_o[i*DataWidth +: DataWidth] =
                        tmo_hit ? DataWidth'(ApbArbErrData) : s_prdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mgr_arbiter.sv
// tb/tb_apb_mgr_arbiter.sv - self-checking bench for apb_mgr_arbiter
module tb_apb_mgr_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_psel, m_penable, m_pwrite;
    logic [N*AW-1:0] m_paddr;
    logic [N*DW-1:0] m_pwdata;
    logic [N*SW-1:0] m_pstrb;
    logic [N*DW-1:0] m_prdata;
    logic [N-1:0]    m_pready, m_pslverr;
    logic            s_psel, s_penable, s_pwrite;
    logic [AW-1:0]   s_paddr;
    logic [DW-1:0]   s_pwdata;
    logic [SW-1:0]   s_pstrb;
    logic [DW-1:0]   s_prdata;
    logic            s_pready, s_pslverr;
    logic [N-1:0]    gnt;

    apb_mgr_arbiter #(
        .NumMgrs(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_psel_i(m_psel), .m_penable_i(m_penable), .m_pwrite_i(m_pwrite),
        .m_paddr_i(m_paddr), .m_pwdata_i(m_pwdata), .m_pstrb_i(m_pstrb),
        .m_prdata_o(m_prdata), .m_pready_o(m_pready), .m_pslverr_o(m_pslverr),
        .s_psel_o(s_psel), .s_penable_o(s_penable), .s_pwrite_o(s_pwrite),
        .s_paddr_o(s_paddr), .s_pwdata_o(s_pwdata), .s_pstrb_o(s_pstrb),
        .s_prdata_i(s_prdata), .s_pready_i(s_pready), .s_pslverr_i(s_pslverr),
        .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } txn_t;

    typedef struct {
        int          mgr;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        err;
        int          exp_lat;
        logic [31:0] exp_prdata;
        logic        exp_err;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    txn_t mq[N][$];
    int   order[$];
    int   phase[N];
    int   waited[N];
    int   ptr_model;
    txn_t nul;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream slave returns data and error derived from the address.
    function automatic logic [31:0] f_rdata(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic f_err(input logic [31:0] a);
        return a[5] & a[2];
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.wr    = 1'($urandom_range(1));
        t.addr  = $urandom & 32'hFFFF_FFFC;
        t.wdata = $urandom;
        t.strb  = 4'($urandom_range(15));
        return t;
    endfunction

    // Round-robin rule: first requester at or after the pointer.
    function automatic int pick_model(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_mgr(input int m, input logic sel, input logic en, input txn_t t);
        m_psel[m]              = sel;
        m_penable[m]           = en;
        m_pwrite[m]            = t.wr;
        m_paddr[m*AW +: AW]    = t.addr;
        m_pwdata[m*DW +: DW]   = t.wdata;
        m_pstrb[m*SW +: SW]    = t.strb;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ctl"}, {s_psel, s_penable, s_pwrite}, 0);
        chk({tag, "_s_paddr"}, s_paddr, 0);
        chk({tag, "_s_pwdata"}, s_pwdata, 0);
        chk({tag, "_s_pstrb"}, s_pstrb, 0);
        chk({tag, "_m_pready"}, m_pready, 0);
        chk({tag, "_m_pslverr"}, m_pslverr, 0);
        chk({tag, "_m_prdata"}, m_prdata, 0);
        chk({tag, "_gnt"}, gnt, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int m = 0; m < N; m++) set_mgr(m, 1'b0, 1'b0, nul);
        s_pready = 1'b0; s_prdata = '0; s_pslverr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr_model = 0;
    endtask

    // Cycle engine: APB managers working through their queues, a slave with
    // random wait states, and transaction-level checks of routing and order.
    task automatic run_engine(input int budget, input int max_ws, input int start_pct);
        int          cyc = 0;
        int          slave_wait = 0;
        int          w;
        logic [31:0] slave_addr = '0;
        logic [N-1:0] prev_req = m_psel;
        bit          all_idle;
        txn_t        t;
        order.delete();
        for (int m = 0; m < N; m++) begin phase[m] = 0; waited[m] = 0; end
        forever begin
            @(negedge clk);
            for (int m = 0; m < N; m++) begin
                if (phase[m] == 0) begin
                    if (mq[m].size() > 0 && $urandom_range(99) < start_pct) begin
                        set_mgr(m, 1'b1, 1'b0, mq[m][0]);
                        phase[m] = 1;
                    end else begin
                        set_mgr(m, 1'b0, 1'b0, nul);
                    end
                end else if (phase[m] == 1) begin
                    m_penable[m] = 1'b1;
                    phase[m] = 2;
                end
            end
            s_pready  = (slave_wait == 0);
            s_prdata  = f_rdata(slave_addr);
            s_pslverr = f_err(slave_addr);
            #1;
            chk("gnt_onehot0", $onehot0(gnt), 1);
            if (s_psel && !s_penable) begin
                w = pick_model(prev_req, ptr_model);
                chk("rr_has_req", |prev_req, 1);
                if (w >= 0 && mq[w].size() > 0) begin
                    chk("rr_winner", gnt, 64'(1) << w);
                    chk("s_paddr", s_paddr, mq[w][0].addr);
                    chk("s_pwrite", s_pwrite, mq[w][0].wr);
                    chk("s_pwdata", s_pwdata, mq[w][0].wdata);
                    chk("s_pstrb", s_pstrb, mq[w][0].strb);
                end
                slave_addr = s_paddr;
                slave_wait = $urandom_range(max_ws);
            end else if (s_psel && s_penable && !s_pready) begin
                slave_wait--;
            end
            for (int m = 0; m < N; m++) begin
                if (m_pready[m]) begin
                    chk("pready_in_access", phase[m], 2);
                    if (phase[m] == 2) begin
                        t = mq[m].pop_front();
                        chk("m_prdata", m_prdata[m*DW +: DW], f_rdata(t.addr));
                        chk("m_pslverr", m_pslverr[m], f_err(t.addr));
                        chk("no_starve", waited[m] <= N - 1, 1);
                        waited[m] = 0;
                        for (int o = 0; o < N; o++) if (o != m && phase[o] != 0) waited[o]++;
                        order.push_back(m);
                        ptr_model = (m + 1) % N;
                        phase[m] = 0;
                    end
                end else begin
                    chk("idle_prdata", m_prdata[m*DW +: DW], 0);
                    chk("idle_pslverr", m_pslverr[m], 0);
                end
            end
            prev_req = m_psel;
            all_idle = 1'b1;
            for (int m = 0; m < N; m++) if (mq[m].size() > 0 || phase[m] != 0) all_idle = 1'b0;
            if (all_idle) begin
                @(negedge clk);
                for (int m = 0; m < N; m++) set_mgr(m, 1'b0, 1'b0, nul);
                return;
            end
            cyc++;
            if (cyc > budget) begin
                chk("engine_budget", cyc, budget);
                for (int m = 0; m < N; m++) begin mq[m].delete(); set_mgr(m, 1'b0, 1'b0, nul); end
                return;
            end
        end
    endtask

    // One transfer by a lone manager with a scripted slave response.
    task automatic run_vec(input vec_t v);
        txn_t        t;
        int          edges = 0;
        int          acc_seen = 0;
        int          lat = -1;
        logic [31:0] got_data = '0;
        logic        got_err = 1'b0;
        int          o = 1 - v.mgr;
        t.wr = v.wr; t.addr = v.addr; t.wdata = v.wdata; t.strb = 4'hF;
        @(negedge clk);
        set_mgr(v.mgr, 1'b1, 1'b0, t);
        set_mgr(o, 1'b0, 1'b0, nul);
        s_pready = 1'b0; s_prdata = v.rdata; s_pslverr = v.err;
        #1;
        chk("v_psel_not_yet", s_psel, 0);
        while (edges < 60) begin
            @(negedge clk);
            edges++;
            m_penable[v.mgr] = 1'b1;
            s_pready = (acc_seen >= v.waits);
            #1;
            if (edges == 1) begin
                chk("v_setup_ctl", {s_psel, s_penable}, 2'b10);
                chk("v_setup_addr", s_paddr, v.addr);
                chk("v_setup_wdata", s_pwdata, v.wdata);
                chk("v_setup_wr", s_pwrite, v.wr);
                chk("v_gnt", gnt, 64'(1) << v.mgr);
            end
            chk("v_other_pready", m_pready[o], 0);
            chk("v_other_prdata", m_prdata[o*DW +: DW], 0);
            if (m_pready[v.mgr]) begin
                lat = edges;
                got_data = m_prdata[v.mgr*DW +: DW];
                got_err = m_pslverr[v.mgr];
                break;
            end
            if (s_psel && s_penable) acc_seen++;
        end
        chk("v_latency", lat, v.exp_lat);
        chk("v_prdata", got_data, v.exp_prdata);
        chk("v_pslverr", got_err, v.exp_err);
        @(negedge clk);
        set_mgr(v.mgr, 1'b0, 1'b0, nul);
        s_pready = 1'b0;
        #1;
        chk("v_pready_one_cycle", m_pready[v.mgr], 0);
        chk("v_idle_gap", s_psel, 0);
        ptr_model = (v.mgr + 1) % N;
    endtask

    vec_t vecs[6];
    txn_t t;
    int   edges;

    initial begin
        nul = '{wr: 1'b0, addr: '0, wdata: '0, strb: '0};
        vecs[0] = '{0, 1'b1, 32'h0001_0000, 32'hCAFE_F00D, 0, 32'h0,         1'b0, 2, 32'h0,         1'b0};
        vecs[1] = '{1, 1'b0, 32'h0000_2004, 32'h0,         5, 32'h1234_5678, 1'b0, 7, 32'h1234_5678, 1'b0};
        vecs[2] = '{0, 1'b0, 32'h0000_0040, 32'h0,         1, 32'hA5A5_0F0F, 1'b1, 3, 32'hA5A5_0F0F, 1'b1};
        vecs[3] = '{1, 1'b1, 32'h8000_0010, 32'h0BAD_C0DE, 2, 32'h0,         1'b1, 4, 32'h0,         1'b1};
        vecs[4] = '{0, 1'b0, 32'h0000_0100, 32'h0,         0, 32'hFFFF_FFFF, 1'b0, 2, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{0, 1'b1, 32'h0000_0104, 32'h1111_2222, 3, 32'h0,         1'b0, 5, 32'h0,         1'b0};

        // Reset state with busy-looking inputs.
        rst_n = 1'b0;
        for (int m = 0; m < N; m++) set_mgr(m, 1'b1, 1'b1, rand_txn());
        s_pready = 1'b1; s_prdata = 32'hFFFF_FFFF; s_pslverr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        do_reset();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Simultaneous requests after reset; manager 0 goes back-to-back.
        do_reset();
        for (int k = 0; k < 2; k++) mq[0].push_back(rand_txn());
        mq[1].push_back(rand_txn());
        run_engine(200, 0, 100);
        chk("pair_count", order.size(), 3);
        if (order.size() == 3) begin
            chk("pair_first", order[0], 0);
            chk("pair_second", order[1], 1);
            chk("pair_third", order[2], 0);
        end

        // Manager 1 aborts in SETUP; the pointer must still move past it.
        t = rand_txn();
        @(negedge clk);
        set_mgr(1, 1'b1, 1'b0, t);
        @(negedge clk);
        #1;
        chk("abort_setup_seen", s_psel, 1);
        set_mgr(1, 1'b0, 1'b0, nul);
        #1;
        chk("abort_psel_drop", s_psel, 0);
        chk("abort_no_pready", m_pready, 0);
        @(negedge clk);
        #1;
        chk("abort_idle", {s_psel, gnt}, 0);
        ptr_model = 0;
        mq[0].push_back(rand_txn());
        mq[1].push_back(rand_txn());
        run_engine(200, 1, 100);
        if (order.size() > 0) chk("abort_ptr_adv", order[0], 0);

        // Reset asserted during ACCESS, pointer left pointing at manager 1.
        mq[0].push_back(rand_txn());
        run_engine(200, 0, 100);
        t = rand_txn();
        @(negedge clk);
        set_mgr(0, 1'b1, 1'b0, t);
        s_pready = 1'b0;
        @(negedge clk);
        m_penable[0] = 1'b1;
        @(negedge clk);
        #1;
        chk("pre_reset_access", {s_psel, s_penable}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        set_mgr(0, 1'b0, 1'b0, nul);
        rst_n = 1'b1;
        ptr_model = 0;
        mq[0].push_back(rand_txn());
        mq[1].push_back(rand_txn());
        run_engine(200, 2, 100);
        if (order.size() > 0) chk("post_rst_prio", order[0], 0);

`ifdef APB_ARB_TIMEOUT_EN
        t = rand_txn();
        t.wr = 1'b0;
        @(negedge clk);
        set_mgr(0, 1'b1, 1'b0, t);
        s_pready = 1'b0;
        edges = 0;
        while (edges < 40) begin
            @(negedge clk);
            edges++;
            m_penable[0] = 1'b1;
            #1;
            if (m_pready[0]) break;
        end
        chk("tmo_latency", edges, 2 + TMO);
        chk("tmo_prdata", m_prdata[DW-1:0], 32'hDEAD_BEEF);
        chk("tmo_pslverr", m_pslverr[0], 1);
        chk("tmo_psel_drop", s_psel, 0);
        @(negedge clk);
        set_mgr(0, 1'b0, 1'b0, nul);
        ptr_model = 1;
`endif

        // Randomized traffic against the transaction-level model.
        for (int k = 0; k < 30; k++) begin
            mq[0].push_back(rand_txn());
            mq[1].push_back(rand_txn());
        end
        run_engine(6000, 3, 60);
        chk("rand_all_done", order.size(), 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
